// File: rtl/sht21_pkg.sv
// Shared types and constants for the SHT21 periodic measurement path.
package sht21_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StTReq,
        StTWait,
        StHReq,
        StHWait,
        StTx
    } seq_state_e;

    typedef enum logic [1:0] {
        TxIdle,
        TxLoad,
        TxWait
    } tx_state_e;

    localparam logic [7:0] CMD_T   = 8'hE3;
    localparam logic [7:0] CMD_H   = 8'hE5;
    localparam logic [7:0] HDR_OK  = 8'hAA;
    localparam logic [7:0] HDR_ERR = 8'hAE;

    localparam int unsigned FRAME_LEN = 6;

    function automatic logic [7:0] frame_sum(input logic [7:0]  hdr,
                                             input logic [15:0] t_word,
                                             input logic [15:0] h_word);
        return hdr + t_word[15:8] + t_word[7:0] + h_word[15:8] + h_word[7:0];
    endfunction

endpackage

// File: rtl/sht21_frame_tx.sv
// Six-byte result frame buffer streamed through one UART transmitter, one byte per handshake.
module sht21_frame_tx
    import sht21_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [15:0] t_word,
    input  logic [15:0] h_word,
    input  logic        fail,
    input  logic        tx_busy,
    output logic [7:0]  tx_data,
    output logic        tx_start,
    output logic        done
);

    localparam logic [2:0] LastIdx = 3'(FRAME_LEN - 1);

    tx_state_e  st_q, st_d;
    logic [7:0] frame_q [FRAME_LEN];
    logic [2:0] idx_q;
    logic       first_q;
    logic [7:0] data_q;
    logic [7:0] hdr;
    logic       advance;

    assign hdr = fail ? HDR_ERR : HDR_OK;

    always_comb begin
        st_d     = st_q;
        tx_start = 1'b0;
        advance  = 1'b0;
        done     = 1'b0;
        unique case (st_q)
            TxIdle: if (load) st_d = TxLoad;
            TxLoad: begin
                if (!tx_busy) begin
                    tx_start = 1'b1;
                    st_d     = TxWait;
                end
            end
            TxWait: begin
                // The UART raises busy one cycle late, so the first wait cycle is blind.
                if (!first_q && !tx_busy) begin
                    advance = 1'b1;
                    if (idx_q == LastIdx) begin
                        done = 1'b1;
                        st_d = TxIdle;
                    end else begin
                        st_d = TxLoad;
                    end
                end
            end
            default: st_d = TxIdle;
        endcase
    end

    assign tx_data = tx_start ? frame_q[idx_q] : data_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            st_q    <= TxIdle;
            idx_q   <= 3'd0;
            first_q <= 1'b0;
            data_q  <= 8'h00;
            for (int i = 0; i < FRAME_LEN; i++) begin
                frame_q[i] <= 8'h00;
            end
        end else begin
            st_q    <= st_d;
            first_q <= tx_start;
            if (load && st_q == TxIdle) begin
                frame_q[0] <= hdr;
                frame_q[1] <= t_word[15:8];
                frame_q[2] <= t_word[7:0];
                frame_q[3] <= h_word[15:8];
                frame_q[4] <= h_word[7:0];
                frame_q[5] <= frame_sum(hdr, t_word, h_word);
                idx_q      <= 3'd0;
            end
            if (tx_start) begin
                data_q <= frame_q[idx_q];
            end
            if (advance) begin
                idx_q <= idx_q + 3'd1;
            end
        end
    end

endmodule

// File: rtl/sht21_meas_sequencer.sv
// Periodic SHT21 scheduler: temperature then humidity conversion per period, then a UART frame.
module sht21_meas_sequencer
    import sht21_pkg::*;
#(
    parameter int unsigned PERIOD_CYC  = 25_000_000,
    parameter int unsigned TIMEOUT_CYC = 2_500_000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        iic_en,
    output logic [7:0]  iic_cmd,
    input  logic [7:0]  iic_rdms,
    input  logic [7:0]  iic_rdls,
    input  logic        iic_ack,
    output logic [7:0]  tx_data,
    output logic        tx_start,
    input  logic        tx_busy,
    output logic [15:0] temp_raw,
    output logic [15:0] hum_raw,
    output logic        meas_valid,
    output logic [7:0]  err_cnt,
    output logic [7:0]  ovr_cnt
);

    localparam int unsigned PW = $clog2(PERIOD_CYC);
    localparam int unsigned TW = $clog2(TIMEOUT_CYC);
    localparam logic [PW-1:0] PerLast = PW'(PERIOD_CYC - 1);
    localparam logic [TW-1:0] ToLast  = TW'(TIMEOUT_CYC - 1);

    seq_state_e  state_q, state_d;
    logic [PW-1:0] per_q;
    logic [TW-1:0] to_q;
    logic [7:0]  cmd_q;
    logic [15:0] t_shadow_q, h_shadow_q;
    logic [15:0] temp_q, hum_q;
    logic        fail_q, done_q, meas_valid_q;
    logic [7:0]  err_q, ovr_q;

    logic        tick, in_wait, got_ack, timeout, frame_load, tx_done;
    logic [15:0] wait_word;

    assign tick       = (per_q == PerLast);
    // done_q holds the wait state one extra cycle so the result settles before advancing.
    assign in_wait    = (state_q == StTWait || state_q == StHWait) && !done_q;
    assign got_ack    = in_wait && iic_ack;
    assign timeout    = (to_q == ToLast);
    assign wait_word  = got_ack ? {iic_rdms, iic_rdls} : 16'hFFFF;
    assign frame_load = (state_q == StHWait) && done_q;

    assign iic_en     = (state_q == StTReq) || (state_q == StHReq);
    assign iic_cmd    = cmd_q;
    assign temp_raw   = temp_q;
    assign hum_raw    = hum_q;
    assign meas_valid = meas_valid_q;
    assign err_cnt    = err_q;
    assign ovr_cnt    = ovr_q;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (tick) state_d = StTReq;
            StTReq:  state_d = StTWait;
            StTWait: if (done_q) state_d = StHReq;
            StHReq:  state_d = StHWait;
            StHWait: if (done_q) state_d = StTx;
            StTx:    if (tx_done) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            per_q        <= '0;
            to_q         <= '0;
            cmd_q        <= 8'h00;
            t_shadow_q   <= 16'h0000;
            h_shadow_q   <= 16'h0000;
            temp_q       <= 16'h0000;
            hum_q        <= 16'h0000;
            fail_q       <= 1'b0;
            done_q       <= 1'b0;
            meas_valid_q <= 1'b0;
            err_q        <= 8'h00;
            ovr_q        <= 8'h00;
        end else begin
            state_q      <= state_d;
            per_q        <= tick ? '0 : per_q + 1'b1;
            meas_valid_q <= 1'b0;
            if (tick && state_q != StIdle && ovr_q != 8'hFF) begin
                ovr_q <= ovr_q + 8'd1;
            end
            if (state_d == StTReq) begin
                cmd_q <= CMD_T;
            end else if (state_d == StHReq) begin
                cmd_q <= CMD_H;
            end
            if (state_q == StIdle && tick) begin
                fail_q <= 1'b0;
            end
            if (state_q == StTReq || state_q == StHReq) begin
                to_q   <= '0;
                done_q <= 1'b0;
            end else if (in_wait) begin
                to_q <= to_q + 1'b1;
                if (got_ack || timeout) begin
                    done_q <= 1'b1;
                    if (!got_ack) begin
                        fail_q <= 1'b1;
                        if (err_q != 8'hFF) err_q <= err_q + 8'd1;
                    end
                    if (state_q == StTWait) begin
                        t_shadow_q <= wait_word;
                    end else begin
                        h_shadow_q   <= wait_word;
                        temp_q       <= t_shadow_q;
                        hum_q        <= wait_word;
                        meas_valid_q <= 1'b1;
                    end
                end
            end
        end
    end

    sht21_frame_tx u_frame_tx (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (frame_load),
        .t_word   (t_shadow_q),
        .h_word   (h_shadow_q),
        .fail     (fail_q),
        .tx_busy  (tx_busy),
        .tx_data  (tx_data),
        .tx_start (tx_start),
        .done     (tx_done)
    );

endmodule

// File: tb/tb_sht21_meas_sequencer.sv
// Scoreboard bench for sht21_meas_sequencer with behavioural IIC and UART models.
module tb_sht21_meas_sequencer;

    localparam int unsigned P  = 200;
    localparam int unsigned TO = 40;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        iic_en;
    logic [7:0]  iic_cmd;
    logic [7:0]  iic_rdms, iic_rdls;
    logic        iic_ack;
    logic [7:0]  tx_data;
    logic        tx_start;
    logic        tx_busy;
    logic [15:0] temp_raw, hum_raw;
    logic        meas_valid;
    logic [7:0]  err_cnt, ovr_cnt;

    sht21_meas_sequencer #(
        .PERIOD_CYC  (P),
        .TIMEOUT_CYC (TO)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .iic_en     (iic_en),
        .iic_cmd    (iic_cmd),
        .iic_rdms   (iic_rdms),
        .iic_rdls   (iic_rdls),
        .iic_ack    (iic_ack),
        .tx_data    (tx_data),
        .tx_start   (tx_start),
        .tx_busy    (tx_busy),
        .temp_raw   (temp_raw),
        .hum_raw    (hum_raw),
        .meas_valid (meas_valid),
        .err_cnt    (err_cnt),
        .ovr_cnt    (ovr_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    // Model configuration, set per scenario.
    logic [7:0] t_ms, t_ls, h_ms, h_ls;
    bit  drop_h   = 1'b0;
    int  dly_t    = 5;
    int  dly_h    = 5;
    int  busy_len = 10;

    // Scoreboard and monitor state.
    logic [7:0]  exp_tx[$];
    logic [31:0] exp_meas[$];
    int         n_tx = 0;
    bit         have_last = 1'b0;
    bit         held = 1'b1;
    logic [7:0] last_data = 8'h00;
    logic [7:0] exp_cmd = 8'hE3;
    bit         have_prev = 1'b0;
    int         prev_en = 0;
    int         prev_ovr = 0;
    bit         t_ack_valid = 1'b0;
    bit         h_ack_valid = 1'b0;
    int         t_ack_cyc = 0;
    int         h_ack_cyc = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // IIC controller model: acks after a delay with data chosen by command.
    initial begin
        bit is_t;
        iic_ack  = 1'b0;
        iic_rdms = 8'h00;
        iic_rdls = 8'h00;
        forever begin
            @(negedge clk);
            if (rst_n && iic_en) begin
                is_t = (iic_cmd == 8'hE3);
                if (is_t || !drop_h) begin
                    repeat (is_t ? dly_t : dly_h) @(posedge clk);
                    #1;
                    iic_ack  = 1'b1;
                    iic_rdms = is_t ? t_ms : h_ms;
                    iic_rdls = is_t ? t_ls : h_ls;
                    if (is_t) begin
                        t_ack_cyc = cyc; t_ack_valid = 1'b1;
                    end else begin
                        h_ack_cyc = cyc; h_ack_valid = 1'b1;
                    end
                    @(posedge clk);
                    #1 iic_ack = 1'b0;
                end
            end
        end
    end

    // UART model: busy for busy_len cycles starting the cycle after tx_start.
    initial begin
        tx_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (tx_start) begin
                @(posedge clk);
                #1 tx_busy = 1'b1;
                repeat (busy_len) @(posedge clk);
                #1 tx_busy = 1'b0;
            end
        end
    end

    // Monitor: pops the scoreboard whenever the DUT presents an output.
    initial begin
        logic [31:0] m;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (tx_start) begin
                    n_tx++;
                    check("tx_start while busy", tx_busy, 0);
                    if (have_last) check("tx_data hold", held, 1);
                    if (exp_tx.size() == 0) begin
                        total++; bad++;
                        $display("FAIL unexpected tx_start: data 0x%0h, want none", tx_data);
                    end else begin
                        check("tx byte", tx_data, exp_tx.pop_front());
                    end
                    last_data = tx_data; have_last = 1'b1; held = 1'b1;
                end else if (have_last && tx_data !== last_data) begin
                    held = 1'b0;
                end
                if (meas_valid) begin
                    if (exp_meas.size() == 0) begin
                        total++; bad++;
                        $display("FAIL unexpected meas_valid: temp 0x%0h hum 0x%0h, want none",
                                 temp_raw, hum_raw);
                    end else begin
                        m = exp_meas.pop_front();
                        check("temp_raw", temp_raw, m[31:16]);
                        check("hum_raw", hum_raw, m[15:0]);
                    end
                    if (h_ack_valid) check("meas_valid latency", cyc - h_ack_cyc, 1);
                    h_ack_valid = 1'b0;
                end
                if (iic_en) begin
                    check("iic_cmd", iic_cmd, exp_cmd);
                    if (exp_cmd == 8'hE5) begin
                        if (t_ack_valid) check("H iic_en latency", cyc - t_ack_cyc, 2);
                        t_ack_valid = 1'b0;
                        exp_cmd = 8'hE3;
                    end else begin
                        if (have_prev) begin
                            check("period alignment", (cyc - prev_en) % P, 0);
                            check("ovr_cnt delta", int'(ovr_cnt) - prev_ovr,
                                  (cyc - prev_en) / P - 1);
                        end
                        prev_en = cyc; prev_ovr = int'(ovr_cnt); have_prev = 1'b1;
                        exp_cmd = 8'hE5;
                    end
                end
            end
        end
    end

    task automatic check_zero(input string tag);
        check({tag, " iic_en"}, iic_en, 0);
        check({tag, " iic_cmd"}, iic_cmd, 0);
        check({tag, " tx_start"}, tx_start, 0);
        check({tag, " tx_data"}, tx_data, 0);
        check({tag, " temp_raw"}, temp_raw, 0);
        check({tag, " hum_raw"}, hum_raw, 0);
        check({tag, " meas_valid"}, meas_valid, 0);
        check({tag, " err_cnt"}, err_cnt, 0);
        check({tag, " ovr_cnt"}, ovr_cnt, 0);
    endtask

    task automatic setup_frame(input logic [7:0] tm, input logic [7:0] tl, input logic [7:0] hm,
                               input logic [7:0] hl, input bit hdrop, input int hdly,
                               input int blen, input logic [7:0] hdr, input logic [7:0] sum);
        t_ms = tm; t_ls = tl; h_ms = hm; h_ls = hl;
        drop_h = hdrop; dly_h = hdly; busy_len = blen;
        exp_tx.push_back(hdr);
        exp_tx.push_back(tm);
        exp_tx.push_back(tl);
        exp_tx.push_back(hdrop ? 8'hFF : hm);
        exp_tx.push_back(hdrop ? 8'hFF : hl);
        exp_tx.push_back(sum);
        exp_meas.push_back({tm, tl, hdrop ? 16'hFFFF : {hm, hl}});
    endtask

    task automatic wait_tx(input int target, input string name);
        int n = 0;
        while (n_tx < target && n < 20000) begin
            @(negedge clk);
            n++;
        end
        check(name, 32'(n_tx >= target), 1);
    endtask

    task automatic wait_first_en(input string name);
        int k = 0;
        @(negedge clk);
        while (!iic_en && k < int'(P) + 50) begin
            @(negedge clk);
            k++;
        end
        check(name, k, P);
    endtask

    task automatic frame(input string tag, input logic [7:0] tm, input logic [7:0] tl,
                         input logic [7:0] hm, input logic [7:0] hl, input bit hdrop,
                         input int hdly, input int blen, input logic [7:0] hdr,
                         input logic [7:0] sum, input int err_exp);
        int base = n_tx;
        setup_frame(tm, tl, hm, hl, hdrop, hdly, blen, hdr, sum);
        wait_tx(base + 6, {tag, " frame complete"});
        check({tag, " err_cnt"}, err_cnt, err_exp);
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: time limit reached, total=%0d", total);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int base;
        int tx0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        check_zero("reset");

        // Nominal: AA+66+7C+5A+36 = 0x21C -> checksum 1C.
        setup_frame(8'h66, 8'h7C, 8'h5A, 8'h36, 1'b0, 5, 10, 8'hAA, 8'h1C);
        @(posedge clk);
        #1 rst_n = 1'b1;
        wait_first_en("first tick latency");
        wait_tx(6, "nominal frame complete");
        check("nominal err_cnt", err_cnt, 0);

        // Humidity timeout: AE+66+7C+FF+FF = 0x38E -> 8E.
        frame("hum timeout", 8'h66, 8'h7C, 8'h00, 8'h00, 1'b1, 5, 10, 8'hAE, 8'h8E, 1);
        check("hum timeout ovr_cnt", ovr_cnt, 0);

        // Ack lands in the timeout cycle: AA+01+02+03+04 = B4.
        frame("collision", 8'h01, 8'h02, 8'h03, 8'h04, 1'b0, TO, 10, 8'hAA, 8'hB4, 1);

        // Slow UART: AA+12+34+56+78 = 0x1BE -> BE.
        frame("slow uart", 8'h12, 8'h34, 8'h56, 8'h78, 1'b0, 5, 1000, 8'hAA, 8'hBE, 1);

        // Overrun with 100-cycle bytes: AA+9A+BC+DE+F0 = 0x3CE -> CE.
        frame("overrun", 8'h9A, 8'hBC, 8'hDE, 8'hF0, 1'b0, 5, 100, 8'hAA, 8'hCE, 1);

        // Reset after byte 2 goes out.
        base = n_tx;
        setup_frame(8'h21, 8'h22, 8'h23, 8'h24, 1'b0, 5, 10, 8'hAA, 8'h34);
        wait_tx(base + 3, "pre-reset bytes");
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        exp_tx.delete();
        have_last = 1'b0; have_prev = 1'b0; exp_cmd = 8'hE3;
        t_ack_valid = 1'b0; h_ack_valid = 1'b0;
        tx0 = n_tx;
        // Post-reset frame: AA+31+32+33+34 = 0x174 -> 74.
        setup_frame(8'h31, 8'h32, 8'h33, 8'h34, 1'b0, 5, 10, 8'hAA, 8'h74);
        wait_first_en("post-reset tick latency");
        check("no tx_start after reset", n_tx - tx0, 0);
        wait_tx(tx0 + 6, "post-reset frame complete");
        check("post-reset err_cnt", err_cnt, 0);

        repeat (20) @(negedge clk);
        check("tx scoreboard drained", exp_tx.size(), 0);
        check("meas scoreboard drained", exp_meas.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
